modbus_uart_rx: RTL
===================

Name: modbus_uart_rx

Overview:
Modbus RTU serial receiver feeding ModbusToWishbone's UART-side input.
- Deserialises the RX line into bytes.
- Presents each byte on a level/acknowledge handshake with parity-error and overflow status.
- Asserts silence after the RTU inter-frame gap (3.5 character times), which the consumer uses as its frame delimiter.
- Sits between the board RX pin and ModbusToWishbone; single clock domain, so uartClk on the consumer ties to the same clk.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit time (50 MHz / 115200); minimum 4.
- PARITY, 2: 0 none, 1 odd, 2 even (Modbus default even).
- STOP_BITS, 1: 1 or 2 stop bits checked.
- SILENCE_BITS, 39: idle bit times before silence asserts (3.5 × 11-bit char, rounded up).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- dataOut  output  9  [7:0] received byte; [8] framing error (stop bit sampled low)
- dataReceived  output  1  byte valid in dataOut, held until accepted
- receiveReq  input  1  consumer accept; single-cycle pulse expected
- parityError  output  1  parity mismatch for byte currently in dataOut
- overflow  output  1  a byte was lost while dataReceived was pending
- silence  output  1  line idle ≥ SILENCE_BITS bit times

Behaviour:
- Reset values:
  - dataOut=0, dataReceived=0, parityError=0, overflow=0, silence=0.
  - FSM=IDLE; idle counter=0; synchroniser flops=1.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value (rxs).
- FSM IDLE:
  - On rxs falling (1→0), go to START and load the bit counter with CLKS_PER_BIT/2.
- FSM START:
  - At half-bit, if rxs=1 it is a false start → IDLE with no output.
  - Otherwise go to DATA and reload the counter to CLKS_PER_BIT.
- FSM DATA:
  - Sample 8 bits at mid-bit, LSB first, into a shift register.
  - Then go to PARITY if PARITY≠0, else STOP.
- FSM PARITY:
  - Sample one bit.
  - Error if (XOR of data ^ bit) ≠ (PARITY==1 ? 1 : 0).
- FSM STOP:
  - Sample STOP_BITS bits; framing error if any sample is 0.
  - On the last stop sample, deliver the byte and go to IDLE.
  - If the stop bit was 0, IDLE waits for rxs=1 before re-arming (no false start from a break).
- Delivery (cycle after the last stop sample):
  - If dataReceived=0, or receiveReq=1 in the same cycle: load dataOut={fe, byte} and parityError, and set dataReceived=1.
  - Otherwise: drop the new byte, keep the old one, and set overflow=1.
- Handshake:
  - receiveReq=1 while dataReceived=1 → dataReceived=0 next cycle (unless a delivery coincides, see above).
  - receiveReq while dataReceived=0 is ignored.
- overflow is sticky; it clears on the next receiveReq that accepts a byte.
- Silence:
  - The idle counter increments every clk while FSM=IDLE and rxs=1, saturating at SILENCE_BITS*CLKS_PER_BIT.
  - silence=1 when saturated.
  - Any rxs=0, or leaving IDLE, clears the counter and silence in the same cycle; the counter restarts from 0 after the stop bit.
  - After reset with an idle line, silence asserts after SILENCE_BITS*CLKS_PER_BIT cycles.
- Async reset mid-byte: the partial byte is discarded, all outputs return to reset values, and the FSM restarts in IDLE.
- Counter widths are sized with $clog2 from the parameters; no wrap is permitted.

Optional Feature:
- MODBUS_UART_RX_MAJORITY_EN
- Defined: each bit value is the majority of 3 rxs samples taken at mid-1, mid, mid+1. This applies to start validation as well.
- Undefined: a single sample at mid-bit.
- Frame timing and latency are identical in both builds.

Test Plan:
- CLKS_PER_BIT=8, even parity: send 0x37 with parity bit 1 → dataOut=0x037, parityError=0, dataReceived high until receiveReq; low 1 cycle after it.
- Send 0x10 with parity bit 0 (wrong for odd-count? 0x10 has one 1, so even requires 1) → dataOut=0x010, parityError=1.
- Send 0xA5 then 0x33 without receiveReq → dataOut stays 0x0A5, overflow=1. A receiveReq then clears dataReceived and overflow.
- Send 0x05, stop bit driven 0 → dataOut[8]=1. No new start is detected until rx returns high.
- Line idle after a byte: silence=0 at 38 bit times, 1 at exactly 39×8 cycles after the stop sample. A 1-cycle low glitch then clears it (bench with MODBUS_UART_RX_MAJORITY_EN: the glitch mid-bit does not alter the data bit).
- Assert rst during DATA bit 4 → all outputs 0 immediately. The next full byte 0xFF is received correctly.

Source files
------------

// File: rtl/modbus_uart_rx_if.sv
// Byte-level handshake bundle between the Modbus RTU receiver and its consumer.
// master = receiver side (drives data/status), slave = consumer side (drives accept).
interface modbus_uart_rx_if;
  logic       rx;
  logic [8:0] dataOut;
  logic       dataReceived;
  logic       receiveReq;
  logic       parityError;
  logic       overflow;
  logic       silence;

  modport master (
    input  rx,
    input  receiveReq,
    output dataOut,
    output dataReceived,
    output parityError,
    output overflow,
    output silence
  );

  modport slave (
    output rx,
    output receiveReq,
    input  dataOut,
    input  dataReceived,
    input  parityError,
    input  overflow,
    input  silence
  );
endinterface

// File: rtl/modbus_uart_rx.sv
// Modbus RTU UART receiver: 8 data bits, optional parity, 1/2 stop bits, inter-frame silence flag.
// Optional MODBUS_UART_RX_MAJORITY_EN: 3-sample majority vote per bit instead of a single mid-bit sample.
module modbus_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 2,
  parameter int STOP_BITS    = 1,
  parameter int SILENCE_BITS = 39
) (
  input  logic              clk,
  input  logic              rst,
  modbus_uart_rx_if.master  bus
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_MAX = SILENCE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_MAX);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic              PAR_ODD   = (PARITY == 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              fe_q, fe_d;
  logic              perr_frame_q, perr_frame_d;
  logic              stop_idx_q, stop_idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [8:0]        dout_q, dout_d;
  logic              dvld_q, dvld_d;
  logic              perr_q, perr_d;
  logic              ovf_q, ovf_d;

  logic              sync1_q, rxs_q, rxs_prev_q;
  logic              bit_smp;
  logic              mid;
  logic              fe_now;
  logic              deliver;
  logic              accept;

`ifdef MODBUS_UART_RX_MAJORITY_EN
  logic rxs_prev2_q;

  // Vote window ends on the decision cycle, so frame timing matches the single-sample build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rxs_prev2_q <= 1'b1;
    else     rxs_prev2_q <= rxs_prev_q;
  end

  assign bit_smp = (rxs_prev2_q & rxs_prev_q) | (rxs_prev2_q & rxs_q) | (rxs_prev_q & rxs_q);
`else
  assign bit_smp = rxs_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= bus.rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign mid    = (cnt_q == CNT_ONE);
  assign fe_now = fe_q | ~bit_smp;
  assign accept = bus.receiveReq & dvld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      fe_q         <= 1'b0;
      perr_frame_q <= 1'b0;
      stop_idx_q   <= 1'b0;
      idle_q       <= '0;
      dout_q       <= '0;
      dvld_q       <= 1'b0;
      perr_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      fe_q         <= fe_d;
      perr_frame_q <= perr_frame_d;
      stop_idx_q   <= stop_idx_d;
      idle_q       <= idle_d;
      dout_q       <= dout_d;
      dvld_q       <= dvld_d;
      perr_q       <= perr_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    fe_d         = fe_q;
    perr_frame_d = perr_frame_q;
    stop_idx_d   = stop_idx_q;
    idle_d       = idle_q;
    dout_d       = dout_q;
    dvld_d       = dvld_q;
    perr_d       = perr_q;
    ovf_d        = ovf_q;
    deliver      = 1'b0;

    case (state_q)
      // Edge-triggered start: a held-low break cannot re-arm until the line goes high.
      S_IDLE: begin
        if (!rxs_q && rxs_prev_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (mid) begin
          if (bit_smp) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_DATA;
            cnt_d        = CNT_FULL;
            bit_idx_d    = '0;
            fe_d         = 1'b0;
            perr_frame_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d   = {bit_smp, shift_q[7:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            if (PARITY != 0) state_d = S_PARITY;
            else             state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PARITY: begin
        if (mid) begin
          perr_frame_d = ((^shift_q) ^ bit_smp) != PAR_ODD;
          cnt_d        = CNT_FULL;
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (mid) begin
          fe_d = fe_now;
          if (stop_idx_q == STOP_LAST) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
            cnt_d      = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      dvld_d = 1'b0;
      ovf_d  = 1'b0;
    end

    // A same-cycle accept frees the slot, so the new byte replaces the old one.
    if (deliver) begin
      if (!dvld_q || bus.receiveReq) begin
        dout_d = {fe_now, shift_q};
        perr_d = perr_frame_q;
        dvld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (state_q == S_IDLE && rxs_q) begin
      if (idle_q != IDLE_SAT) idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = '0;
    end
  end

  assign bus.dataOut      = dout_q;
  assign bus.dataReceived = dvld_q;
  assign bus.parityError  = perr_q;
  assign bus.overflow     = ovf_q;
  assign bus.silence      = (idle_q == IDLE_SAT) && (state_q == S_IDLE) && rxs_q;

endmodule
